// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-sequencer bus: run control and Next_Addr in, PC and run status out.
// FETCH_STALL_CNT_EN adds the Stall_Cnt signal.
interface pc_fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [31:0]      Next_Addr;
  logic [31:0]      PC_Addr;
  logic             Exec_Valid;
  logic             Done;
  logic             Err;
  logic [CNT_W-1:0] Retired_Cnt;
`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] Stall_Cnt;
`endif

`ifdef FETCH_STALL_CNT_EN
  modport master (output start, stall, Next_Addr,
                  input  PC_Addr, Exec_Valid, Done, Err, Retired_Cnt, Stall_Cnt);
  modport slave  (input  start, stall, Next_Addr,
                  output PC_Addr, Exec_Valid, Done, Err, Retired_Cnt, Stall_Cnt);
`else
  modport master (output start, stall, Next_Addr,
                  input  PC_Addr, Exec_Valid, Done, Err, Retired_Cnt);
  modport slave  (input  start, stall, Next_Addr,
                  output PC_Addr, Exec_Valid, Done, Err, Retired_Cnt);
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and run sequencer (idle/run/done/error) for the single-cycle CPU.
// Optional FETCH_STALL_CNT_EN adds a saturating stalled-cycle counter.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] END_ADDR   = 32'd124,
  parameter int          CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  pc_fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t           state_q, state_n;
  logic [31:0]      pc_q, pc_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             exec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    cnt_n   = cnt_q;
    exec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_RUN;
          pc_n    = RESET_ADDR;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          exec  = 1'b1;
          cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          // End match wins over alignment: Next_Addr past the last instruction is don't-care.
          if (pc_q == END_ADDR)
            state_n = S_DONE;
          else if (bus.Next_Addr[1:0] != 2'b00)
            state_n = S_ERR;
          else
            pc_n = bus.Next_Addr;
        end
      end
      S_DONE, S_ERR: begin
        if (bus.start) begin
          state_n = S_RUN;
          pc_n    = RESET_ADDR;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.PC_Addr     = pc_q;
  assign bus.Exec_Valid  = exec;
  assign bus.Done        = (state_q == S_DONE);
  assign bus.Err         = (state_q == S_ERR);
  assign bus.Retired_Cnt = cnt_q;

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] scnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scnt_q <= '0;
    else if (state_q != S_RUN && bus.start)
      scnt_q <= '0;
    else if (state_q == S_RUN && bus.stall && scnt_q != '1)
      scnt_q <= scnt_q + 1'b1;
  end

  assign bus.Stall_Cnt = scnt_q;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboarded bench for pc_fetch_ctrl: END_ADDR=12, narrow counters to reach saturation.
module tb_pc_fetch_ctrl;
  localparam int CW = 3;
  localparam logic [31:0] END_A = 32'd12;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.CNT_W(CW)) bus ();

  pc_fetch_ctrl #(.RESET_ADDR(32'd0), .END_ADDR(END_A), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]   pc;
    logic          ev;
    logic          dn;
    logic          er;
    logic [CW-1:0] cnt;
    logic [CW-1:0] scnt;
  } exp_t;
  exp_t sb[$];

  int            m_state;
  logic [31:0]   m_pc;
  logic [CW-1:0] m_cnt, m_scnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pc = 32'd0; m_cnt = '0; m_scnt = '0;
  endtask

  // One clock cycle: drive after negedge, push/pop expectation, advance model on posedge.
  task automatic cycle(input logic st, input logic sl, input logic frc, input logic [31:0] fval);
    exp_t e, o;
    logic [31:0] nxt;
    @(negedge clk);
    nxt = frc ? fval : m_pc + 32'd4;
    bus.start = st; bus.stall = sl; bus.Next_Addr = nxt;
    e.pc = m_pc; e.ev = (m_state == M_RUN) && !sl;
    e.dn = (m_state == M_DONE); e.er = (m_state == M_ERR);
    e.cnt = m_cnt; e.scnt = m_scnt;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk("pc", bus.PC_Addr, o.pc);
    chk("exec", {31'd0, bus.Exec_Valid}, {31'd0, o.ev});
    chk("done", {31'd0, bus.Done}, {31'd0, o.dn});
    chk("err", {31'd0, bus.Err}, {31'd0, o.er});
    chk("cnt", {29'd0, bus.Retired_Cnt}, {29'd0, o.cnt});
`ifdef FETCH_STALL_CNT_EN
    chk("scnt", {29'd0, bus.Stall_Cnt}, {29'd0, o.scnt});
`endif
    @(posedge clk);
    case (m_state)
      M_RUN: begin
        if (sl) m_scnt = sat_inc(m_scnt);
        else begin
          m_cnt = sat_inc(m_cnt);
          if (m_pc == END_A) m_state = M_DONE;
          else if (nxt[1:0] != 2'b00) m_state = M_ERR;
          else m_pc = nxt;
        end
      end
      default: if (st) begin
        m_state = M_RUN; m_pc = 32'd0; m_cnt = '0; m_scnt = '0;
      end
    endcase
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.Next_Addr = 32'd4;
    model_reset();
    // Reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", bus.PC_Addr, 32'd0);
    chk("rst_exec", {31'd0, bus.Exec_Valid}, 32'd0);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_err", {31'd0, bus.Err}, 32'd0);
    chk("rst_cnt", {29'd0, bus.Retired_Cnt}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run(5);

    // Normal run to END_ADDR.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    run(5);
    chk("run_done", {31'd0, bus.Done}, 32'd1);
    chk("run_cnt", {29'd0, bus.Retired_Cnt}, 32'd4);
    chk("run_pc", bus.PC_Addr, 32'd12);

    // Restart from DONE; start mid-run ignored.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rs_pc", bus.PC_Addr, 32'd0);
    chk("rs_done", {31'd0, bus.Done}, 32'd0);
    chk("rs_cnt", {29'd0, bus.Retired_Cnt}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("ign_pc", bus.PC_Addr, 32'd8);
    run(3);
    chk("ign_done", {31'd0, bus.Done}, 32'd1);
    chk("ign_cnt", {29'd0, bus.Retired_Cnt}, 32'd4);

    // Two stall cycles at PC=4.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("stl_pc", bus.PC_Addr, 32'd4);
    chk("stl_cnt", {29'd0, bus.Retired_Cnt}, 32'd1);
    run(4);
    chk("stl_done", {31'd0, bus.Done}, 32'd1);
    chk("stl_rcnt", {29'd0, bus.Retired_Cnt}, 32'd4);
`ifdef FETCH_STALL_CNT_EN
    chk("stl_scnt", {29'd0, bus.Stall_Cnt}, 32'd2);
`endif

    // Misaligned Next_Addr at PC=4.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'd6);
    chk("mis_err", {31'd0, bus.Err}, 32'd1);
    chk("mis_pc", bus.PC_Addr, 32'd4);
    chk("mis_cnt", {29'd0, bus.Retired_Cnt}, 32'd2);
    chk("mis_exec", {31'd0, bus.Exec_Valid}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("mrs_pc", bus.PC_Addr, 32'd0);
    chk("mrs_err", {31'd0, bus.Err}, 32'd0);
    chk("mrs_cnt", {29'd0, bus.Retired_Cnt}, 32'd0);

    // Loop on PC=0 via Next_Addr=0 to saturate the retire count, plus long stall.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
    chk("sat_cnt", {29'd0, bus.Retired_Cnt}, 32'd7);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    chk("sat_scnt", {29'd0, bus.Stall_Cnt}, 32'd7);
`endif

    // Async reset mid-run at PC=8.
    run(2);
    chk("pre_rst_pc", bus.PC_Addr, 32'd8);
    @(negedge clk);
    bus.start = 1'b0; bus.stall = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mr_pc", bus.PC_Addr, 32'd0);
    chk("mr_exec", {31'd0, bus.Exec_Valid}, 32'd0);
    chk("mr_cnt", {29'd0, bus.Retired_Cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(2);
    chk("mr_idle_exec", {31'd0, bus.Exec_Valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch sequencer for the single-cycle R-format CPU. It owns the PC register, drives the CPU's instruction address and consumes the CPU's PC+4 result. It also sequences program start, stall, normal end and misaligned-address error. It emits a per-cycle execute qualifier that the integration top ANDs into the register-file write enable, so no register is written while the program is idle, stalled or finished.

## Interface
- RESET_ADDR, 32'd0: PC value after reset and on restart.
- END_ADDR, 32'd124: address of the last program instruction; retiring it ends the run.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle request to begin or restart a run.
- stall  in  1  hold current instruction; no retire this cycle.
- Next_Addr  in  32  next sequential address from the CPU adder (PC+4).
- PC_Addr  out  32  current PC, drives CPU instruction address.
- Exec_Valid  out  1  current instruction retires this cycle; gates RegWrite.
- Done  out  1  program reached END_ADDR and halted.
- Err  out  1  misaligned Next_Addr detected and halted.
- Retired_Cnt  out  CNT_W  instructions retired in current run.

## Operation
- State machine: IDLE, RUN, DONE, ERR.
- IDLE: PC_Addr=RESET_ADDR, Exec_Valid=0. start=1 → RUN.
- RUN, stall=1: Exec_Valid=0; PC, count and state hold.
- RUN, stall=0: Exec_Valid=1; Retired_Cnt increments.
  - PC_Addr==END_ADDR: PC holds; → DONE. Next_Addr is ignored.
  - Else if Next_Addr[1:0]!=0: PC holds; → ERR.
  - Else: PC_Addr<=Next_Addr; stay RUN.
- Priority in RUN: stall > END_ADDR match > misalignment > advance.
- DONE: Done=1, Exec_Valid=0, PC and count hold. start=1 → PC<=RESET_ADDR, count<=0, → RUN.
- ERR: Err=1, Exec_Valid=0, PC holds at the offending instruction's address. start=1 → same restart as DONE.
- start is ignored in RUN.
- Retired_Cnt saturates at all-ones and never wraps.
- Next_Addr is not range-checked beyond alignment. The PC wraps naturally with 32-bit arithmetic; the CPU computes that arithmetic, not this block.

## Timing
- Reset (asynchronous, immediate, no edge needed):
  - PC_Addr=RESET_ADDR, Retired_Cnt=0, Done=0, Err=0, Exec_Valid=0, state IDLE.
  - Stall counter, when configured, also resets to 0.
- PC_Addr, Retired_Cnt, Done and Err are registered.
- Exec_Valid is combinational: (state==RUN) & ~stall.
- Start latency: start sampled high at edge N; first instruction executes with Exec_Valid=1 in cycle N+1.
- Advance latency: one cycle per retired instruction. The CPU reads PC_Addr, and Next_Addr settles within the same cycle.
- Done or Err asserts the cycle after the final or offending retire, and stays asserted until restart or reset.
- rst asserted mid-run aborts immediately. No partial retire is counted for that cycle.

## Configuration
- FETCH_STALL_CNT_EN
  - Defined: adds output Stall_Cnt [CNT_W-1:0], registered, counting cycles with state==RUN and stall=1. It saturates at all-ones, clears on reset and on restart, and holds in IDLE, DONE and ERR.
  - Undefined: the port and its counter logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst with no clock edge → PC_Addr=0, Exec_Valid=0, Done=0, Err=0, Retired_Cnt=0. Start held low for 5 cycles → outputs unchanged.
- Normal run, END_ADDR=12, Next_Addr=PC+4, pulse start → over 4 cycles PC_Addr=0,4,8,12 with Exec_Valid=1 → next cycle Done=1, Exec_Valid=0, Retired_Cnt=4, PC_Addr=12.
- Stall, END_ADDR=12, stall=1 for 2 cycles while PC_Addr=4 → PC stays 4, Exec_Valid=0, Retired_Cnt stays 1 during the stall → Done after 6 run cycles, Retired_Cnt=4. With FETCH_STALL_CNT_EN: Stall_Cnt=2.
- Misaligned: at PC_Addr=4 force Next_Addr=6 → that cycle Exec_Valid=1 → next cycle Err=1, PC_Addr=4, Retired_Cnt=2, Exec_Valid=0. Start pulse → PC_Addr=0, Retired_Cnt=0, Err=0, RUN.
- Restart from DONE: pulse start → PC_Addr=0, Retired_Cnt=0, Done=0. Start pulsed again mid-run → ignored, sequence unchanged.
- Async reset mid-run at PC_Addr=8 → PC_Addr=0 and Exec_Valid=0 before the next clock edge, Retired_Cnt=0, state IDLE.
